// File: rtl/nvme_track_arb_pkg.sv
// Shared types and helpers for the completion-tracker update arbiter.
// Action ID width falls back to a local value when the NVMe defines are absent.
`ifndef CMD_ACTION_ID_BITS
`define CMD_ACTION_ID_BITS 4
`endif

package nvme_track_arb_pkg;

    localparam int CMD_ACTION_ID_BITS = `CMD_ACTION_ID_BITS;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } track_arb_state_t;

    // Counter must be able to hold TIMEOUT_CYCLES itself.
    function automatic int TRACK_ARB_CNT_BITS(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/nvme_rr_arbiter.sv
// Combinational round-robin picker: lowest requester above last_grant_i wins,
// otherwise wrap around to the lowest requester overall.
module nvme_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               grant_valid_o
);

    logic [NUM_REQ-1:0] mask_hi;
    logic [NUM_REQ-1:0] req_hi;
    logic [IDX_W-1:0]   sel_lo;
    logic [IDX_W-1:0]   sel_hi;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
        assign mask_hi[gi] = (IDX_W'(gi) > last_grant_i);
        assign grant_o[gi] = grant_valid_o && (grant_idx_o == IDX_W'(gi));
    end

    assign req_hi        = req_i & mask_hi;
    assign grant_valid_o = |req_i;

    always_comb begin
        sel_lo = '0;
        sel_hi = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) sel_lo = IDX_W'(i);
            if (req_hi[i]) sel_hi = IDX_W'(i);
        end
        grant_idx_o = (|req_hi) ? sel_hi : sel_lo;
    end

endmodule

// File: rtl/nvme_track_arb.sv
// Serialises per-requester completion-status lookups onto the single tracker
// update port, with per-transaction timeout and abort when the tracker de-inits.
module nvme_track_arb
    import nvme_track_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int TRACK_INFO_BITS = 2,
    parameter int TIMEOUT_CYCLES  = 1023
) (
    input  logic                                  axi_aclk,
    input  logic                                  axi_areset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ*CMD_ACTION_ID_BITS-1:0] req_id,
    output logic [NUM_REQ-1:0]                    req_ack,
    output logic [NUM_REQ-1:0]                    resp_valid,
    output logic [TRACK_INFO_BITS-1:0]            resp_data,
    output logic                                  resp_err,
    input  logic                                  track_init,
    output logic                                  track_update,
    output logic [CMD_ACTION_ID_BITS-1:0]         track_update_id,
    input  logic                                  track_update_done,
    input  logic [TRACK_INFO_BITS-1:0]            track_update_data,
    input  logic                                  timeout_clear,
    output logic                                  arb_timeout,
    output logic                                  arb_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int ID_W  = CMD_ACTION_ID_BITS;
    localparam int CNT_W = TRACK_ARB_CNT_BITS(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    track_arb_state_t             state_q;
    logic [IDX_W-1:0]             last_grant_q;
    logic [IDX_W-1:0]             owner_q;
    logic [ID_W-1:0]              id_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [TRACK_INFO_BITS-1:0]   resp_data_q;
    logic                         resp_err_q;
    logic                         abort_q;
    logic                         timeout_q;

    logic [NUM_REQ-1:0]           rr_grant;
    logic [IDX_W-1:0]             rr_idx;
    logic                         rr_any;
    logic                         grant_now;
    logic [ID_W-1:0]              req_id_arr [NUM_REQ];

    nvme_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i         (req_valid),
        .last_grant_i  (last_grant_q),
        .grant_o       (rr_grant),
        .grant_idx_o   (rr_idx),
        .grant_valid_o (rr_any)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_id_arr[gi] = req_id[gi*ID_W +: ID_W];
        assign resp_valid[gi] = (state_q == ST_RESP) && (owner_q == IDX_W'(gi));
    end

    // Grant is combinational so the ack lands in the same cycle the request is seen.
    assign grant_now       = (state_q == ST_IDLE) && track_init && rr_any;
    assign req_ack         = grant_now ? rr_grant : '0;
    assign track_update    = (state_q == ST_ISSUE);
    assign track_update_id = id_q;
    assign resp_data       = resp_data_q;
    assign resp_err        = resp_err_q;
    assign arb_timeout     = timeout_q;
    assign arb_busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_RESP);

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q      <= ST_INIT;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            owner_q      <= '0;
            id_q         <= '0;
            cnt_q        <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            abort_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            // A timeout set further down overrides this clear.
            if (timeout_clear) timeout_q <= 1'b0;

            case (state_q)
                ST_INIT: begin
                    if (track_init) state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (!track_init) begin
                        state_q <= ST_INIT;
                    end else if (rr_any) begin
                        last_grant_q <= rr_idx;
                        owner_q      <= rr_idx;
                        id_q         <= req_id_arr[rr_idx];
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q <= '0;
                    if (!track_init) begin
                        resp_err_q  <= 1'b1;
                        resp_data_q <= '0;
                        abort_q     <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!track_init) begin
                        resp_err_q  <= 1'b1;
                        resp_data_q <= '0;
                        abort_q     <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (track_update_done) begin
                        resp_err_q  <= 1'b0;
                        resp_data_q <= track_update_data;
                        state_q     <= ST_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_q   <= 1'b1;
                        resp_err_q  <= 1'b1;
                        resp_data_q <= '0;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    abort_q <= 1'b0;
                    state_q <= abort_q ? ST_INIT : ST_IDLE;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

endmodule

// File: doc/nvme_track_arb.md
# nvme_track_arb

Round-robin scheduler that shares the single I/O-completion tracker update port among `NUM_REQ` action requesters. Each requester asks for the next in-order completion status of one action ID. The block serialises these requests onto `track_update`/`track_update_id` and holds the ID stable until `track_update_done`. It returns `track_update_data` to the granted requester and bounds every transaction with a timeout. It sits between the action-side command engines and the completion tracker.

## Interface

**Parameters**

- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `TRACK_INFO_BITS`, default 2: tracker entry width; bit 0 = valid, bit 1 = error status.
- `TIMEOUT_CYCLES`, default 1023: maximum cycles spent in WAIT.

**Ports** (clock and reset first)

- `axi_aclk` in 1: clock.
- `axi_areset` in 1: reset. **Synchronous, active-high. One clock domain.**
- `req_valid` in NUM_REQ: per-requester request. Held high until `req_ack`.
- `req_id` in NUM_REQ*`CMD_ACTION_ID_BITS`: packed action IDs. Requester i uses slice i. Stable while `req_valid` is high.
- `req_ack` out NUM_REQ: one-hot, one-cycle grant pulse.
- `resp_valid` out NUM_REQ: one-hot, one-cycle response pulse.
- `resp_data` out TRACK_INFO_BITS: tracker data. Valid only with `resp_valid`.
- `resp_err` out 1: qualifies `resp_valid`. 1 = timeout or abort, and `resp_data` = 0.
- `track_init` in 1: tracker memory initialised.
- `track_update` out 1: one-cycle update strobe to the tracker.
- `track_update_id` out `CMD_ACTION_ID_BITS`: action ID. Held constant from strobe until done.
- `track_update_done` in 1: tracker response strobe.
- `track_update_data` in TRACK_INFO_BITS: tracker response data.
- `timeout_clear` in 1: clears `arb_timeout`.
- `arb_timeout` out 1: sticky; set on any timeout.
- `arb_busy` out 1: high in ISSUE, WAIT and RESP.

## Operation

**FSM states:** INIT, IDLE, ISSUE, WAIT, RESP.

- **INIT:** wait for `track_init`=1, then go to IDLE.
- **IDLE:** if any `req_valid` is set:
  - Pick winner w round-robin. Search starts at `last_grant+1` mod NUM_REQ.
  - Pulse `req_ack[w]`, latch `req_id[w]` into `track_update_id`, and latch w.
  - Set `last_grant`=w and go to ISSUE.
- **ISSUE:** `track_update`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- **WAIT:**
  - On `track_update_done`: latch `track_update_data`, set `resp_err`=0, go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: set `arb_timeout`, `resp_err`=1, data 0, go to RESP.
  - Else increment the counter.
- **RESP:** pulse `resp_valid[w]` with the latched data and err. Go to IDLE.

**Global rules:**

- **`track_init` drops:** if `track_init`=0 in ISSUE or WAIT, an in-flight grant is aborted. The block emits `resp_valid[w]` with `resp_err`=1 in the next cycle (RESP), then goes to INIT. If `track_init`=0 in IDLE, the block goes straight to INIT.
- **Late done:** a `track_update_done` arriving outside WAIT is ignored.
- **Requester without grant:** a requester dropping `req_valid` before ack is a protocol violation; behaviour is unspecified.
- **Timeout clear:** `timeout_clear` and a same-cycle timeout set together leave `arb_timeout`=1 (set wins).
- **Widths:** the timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits. `last_grant` is `$clog2(NUM_REQ)` bits and wraps NUM_REQ-1 → 0.

## Timing

- **Reset values:** all outputs 0, including `track_update_id`=0 and `resp_data`=0. State = INIT. `last_grant` = NUM_REQ-1, so requester 0 wins first.
- **Grant latency:** request seen in IDLE at cycle t → `req_ack` at t, `track_update` at t+1.
- **Response latency:** done at cycle d → `resp_valid` at d+1. Earliest next `req_ack` is d+2.
- **Minimum transaction:** done at the earliest permitted cycle, t+2 (one cycle after the strobe) → 4 cycles per transaction.
- **Timeout timing:** with no done, `resp_err` pulses at t+2+TIMEOUT_CYCLES.
- **Reset mid-transaction:** `axi_areset` mid-transaction drops all pulses at the next edge. No response is emitted.
- **Strobe spacing:** `track_update` is never asserted on consecutive cycles. There is at most one outstanding update.

## Structure

- **Shared package** `nvme_track_arb_pkg`: the state enum `track_arb_state_t` and a `TRACK_ARB_CNT_BITS` helper function.
- **Shared defines:** `CMD_ACTION_ID_BITS` stays in the shared NVMe defines include.
- **Sub-module** `nvme_rr_arbiter`: combinational round-robin picker. Inputs: request vector, `last_grant`. Outputs: one-hot grant and encoded index. It is reusable by other NVMe queue schedulers.

## Test plan

1. **Reset, init, single request:** reset, hold `track_init`=0 for 20 cycles then 1, assert `req_valid[2]` with id 5.
   - `req_ack[2]` pulses, `track_update` pulses once with id=5.
   - Done driven 3 cycles after the strobe with data 2'b01 → `resp_valid[2]`=1, `resp_data`=01, `resp_err`=0 one cycle later.
2. **Round-robin fairness:** all 4 requesters held valid continuously with distinct IDs.
   - Grant order is 0,1,2,3,0.
   - `track_update_id` stays constant between each strobe and its done.
3. **Timeout:** `TIMEOUT_CYCLES`=16, no done is ever driven.
   - `resp_err`=1 and `resp_data`=0 exactly 18 cycles after the ack; `arb_timeout`=1.
   - `timeout_clear` clears it; the next transaction completes normally.
4. **Abort on `track_init` drop:** drop `track_init` during WAIT.
   - `resp_valid` pulses with `resp_err`=1 the next cycle, state goes to INIT.
   - No `track_update` until `track_init` returns to 1.
5. **Stray done and spacing:** `track_update_done` pulsed while IDLE → ignored, no `resp_valid`.
   - Back-to-back requests: assert `track_update` is never high on two consecutive cycles and never without a prior ack.
6. **Synchronous reset mid-transaction:** assert `axi_areset` during WAIT.
   - All outputs are 0 on the next edge and no response is issued.
   - After release, requester 0 has priority.
